fpga_dump_scheduler: RTL
========================

// Module: fpga_dump_scheduler
// PURPOSE
//  Sequences block-RAM dumps onto an AXI4-Stream master in DMA-paced bursts.
//  The HPS programs base/length over Avalon-MM; the block requests each burst
//  with dma_req/dma_single, waits for dma_ack, then streams that burst of bytes
//  from the RAM read port. Sits between the 4 KB source RAM and the HPS DMA peripheral-request lines.
// PARAMETERS
//  ADDR_WIDTH  12  RAM byte-address width (RAM depth 2**ADDR_WIDTH)
//  DATA_WIDTH  8   RAM/stream data width
//  BURST_LEN   16  beats per burst request (power of 2, >=2)
// PORTS
//  clk             in   1          system clock
//  reset_n         in   1          async active-low reset
//  avs_address     in   2          CSR select: 0 CTRL, 1 BASE, 2 LEN, 3 STAT
//  avs_chipselect  in   1          CSR access strobe
//  avs_write_n     in   1          0 = write
//  avs_writedata   in   32         CSR write data
//  avs_readdata    out  32         CSR read data, combinational from avs_address
//  mem_rd_en       out  1          RAM read strobe
//  mem_addr        out  ADDR_WIDTH RAM read address
//  mem_rdata       in   DATA_WIDTH RAM data, valid 1 cycle after mem_rd_en
//  axis4_m_tdata   out  DATA_WIDTH stream data
//  axis4_m_tvalid  out  1          stream valid
//  axis4_m_tlast   out  1          last byte of whole transfer
//  axis4_m_tready  in   1          stream ready
//  dma_req         out  1          burst request (>=BURST_LEN bytes remaining)
//  dma_single      out  1          single request (<BURST_LEN remaining)
//  dma_ack         in   1          1-cycle grant pulse for the pending request
// BEHAVIOUR
//  Reset: all outputs 0, CSRs 0, FSM IDLE.
//  CSRs: CTRL[0] start (W1, self-clearing), CTRL[1] abort (W1), CTRL[31] clear STAT
//   done/aborted; BASE[ADDR_WIDTH-1:0]; LEN[ADDR_WIDTH:0] bytes.
//   STAT[0] busy, [1] done, [2] aborted, [28:16] beats sent.
//   BASE/LEN writes and start are ignored while busy; reads always allowed.
//  Transfer setup:
//   - start in IDLE with LEN=0: done=1 next cycle, no stream beats.
//   - start with LEN>0: clear count/done/aborted, set busy, load remaining=LEN
//     and ptr=BASE, then go to REQ.
//   - start and abort in the same write: abort wins, no transfer.
//  FSM:
//   - IDLE -> REQ on an accepted start.
//   - REQ: assert dma_req if remaining>=BURST_LEN, else dma_single (exactly one
//     high). Set burst_cnt = min(remaining, BURST_LEN). On dma_ack, drop the
//     request the next cycle and go to BURST. Abort in REQ: drop the request
//     immediately, aborted=1, go to IDLE.
//   - BURST: issue mem_rd_en when burst_cnt>0 and the output slot is free next
//     cycle (tvalid=0, or tvalid&tready). Data loads into tdata the next cycle
//     with tvalid=1. Sustained rate is 1 byte/clk while tready=1.
//     Each handshake: remaining--, count++.
//     tvalid/tdata hold stable while tready=0.
//   - Burst end (last beat of burst handshaken):
//       - remaining=0: go to IDLE, busy=0, done=1.
//       - remaining>0: go to REQ.
//       - a latched abort: aborted=1, go to IDLE.
//   - Abort in BURST is latched and never truncates a granted burst.
//  ptr increments mod 2**ADDR_WIDTH (BASE+LEN > depth wraps to 0).
//  tlast=1 only with the final beat of the transfer (remaining=1); never on abort.
//  dma_ack outside REQ is ignored.
//  Reset mid-transfer returns everything to reset values next edge; no tlast is emitted.
// TESTING
//  1. BASE=0, LEN=16, BURST=16, tready=1 -> dma_req until ack; 16 beats on
//     consecutive cycles, bytes mem[0..15]; tlast on beat 16; STAT=0x00100002.
//  2. BASE=0, LEN=20 -> dma_req/ack, 16 beats, then dma_single/ack, 4 beats,
//     tlast on beat 20; count=20.
//  3. BASE=0xFFE, LEN=4 -> addresses FFE,FFF,000,001; done=1.
//  4. LEN=32, tready toggled 1/0 per cycle -> tdata stable while tready=0,
//     32 beats, no duplicates or drops.
//  5. Abort in REQ -> dma_req low next cycle, aborted=1. Abort mid-burst ->
//     burst completes (16 beats), then IDLE, aborted=1, no tlast.
//  6. LEN=0 start -> done=1, no dma_req. Write BASE while busy -> BASE unchanged.

Source files
------------

// File: rtl/fpga_dump_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpga_dump_scheduler_if : CSR, RAM-read, AXI4-Stream and DMA signals  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fpga_dump_scheduler_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            avs_address;
  logic                  avs_chipselect;
  logic                  avs_write_n;
  logic [31:0]           avs_writedata;
  logic [31:0]           avs_readdata;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] axis4_m_tdata;
  logic                  axis4_m_tvalid;
  logic                  axis4_m_tlast;
  logic                  axis4_m_tready;
  logic                  dma_req;
  logic                  dma_single;
  logic                  dma_ack;

  modport master (
    input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
    output avs_readdata,
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast,
    input  axis4_m_tready,
    output dma_req, dma_single,
    input  dma_ack
  );

  modport slave (
    output avs_address, avs_chipselect, avs_write_n, avs_writedata,
    input  avs_readdata,
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast,
    output axis4_m_tready,
    input  dma_req, dma_single,
    output dma_ack
  );
endinterface
`default_nettype wire

// File: rtl/fpga_dump_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpga_dump_scheduler : DMA-paced burst dump of a byte RAM to AXI4-S   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fpga_dump_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  wire logic             clk_i,
  input  wire logic             reset_n_i,
  fpga_dump_scheduler_if.master bus_if
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [LW-1:0] c_burst_lw = LW'(BURST_LEN);
  localparam logic [CW-1:0] c_burst_cw = CW'(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, ptr_q;
  logic [LW-1:0]         len_q, rem_q, count_q;
  logic                  done_q, aborted_q, abort_pend_q;
  logic [CW-1:0]         rd_cnt_q, hs_cnt_q;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] tdata_q, skid_q;
  logic                  tvalid_q, skid_v_q;

  logic        w_wr, w_ctrl_wr, w_abort, w_start, w_clear, w_busy;
  logic        w_hs, w_burst_end, w_last_byte, w_abort_now, w_rd_en;
  logic [CW-1:0] w_grant;
  logic [2:0]  w_fill;
  logic [31:0] w_readdata;

  assign w_wr        = bus_if.avs_chipselect & ~bus_if.avs_write_n;
  assign w_ctrl_wr   = w_wr & (bus_if.avs_address == 2'd0);
  assign w_abort     = w_ctrl_wr & bus_if.avs_writedata[1];
  assign w_start     = w_ctrl_wr & bus_if.avs_writedata[0] & ~bus_if.avs_writedata[1];
  assign w_clear     = w_ctrl_wr & bus_if.avs_writedata[31];
  assign w_busy      = (state_q != S_IDLE);
  assign w_hs        = tvalid_q & bus_if.axis4_m_tready;
  assign w_last_byte = (rem_q == LW'(1));
  assign w_burst_end = (state_q == S_BURST) & w_hs & (hs_cnt_q == CW'(1));
  assign w_abort_now = abort_pend_q | w_abort;
  assign w_grant     = (rem_q >= c_burst_lw) ? c_burst_cw : rem_q[CW-1:0];

  // Output head plus one skid slot: a read is issued only if its byte is
  // guaranteed a slot when it lands, even if tready drops in between.
  assign w_fill  = {2'b0, tvalid_q} + {2'b0, skid_v_q} + {2'b0, rd_pend_q};
  assign w_rd_en = (state_q == S_BURST) && (rd_cnt_q != '0) &&
                   (w_fill < (3'd2 + {2'b0, w_hs}));

  always_comb begin
    w_readdata = '0;
    case (bus_if.avs_address)
      2'd1: w_readdata[ADDR_WIDTH-1:0] = base_q;
      2'd2: w_readdata[LW-1:0]         = len_q;
      2'd3: begin
        w_readdata[0]       = w_busy;
        w_readdata[1]       = done_q;
        w_readdata[2]       = aborted_q;
        w_readdata[16 +: LW] = count_q;
      end
      default: w_readdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start && (len_q != '0)) state_d = S_REQ;
      S_REQ: begin
        if (w_abort)              state_d = S_IDLE;
        else if (bus_if.dma_ack)  state_d = S_BURST;
      end
      S_BURST: if (w_burst_end) state_d = (w_last_byte || w_abort_now) ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      ptr_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      rd_cnt_q     <= '0;
      hs_cnt_q     <= '0;
      rd_pend_q    <= 1'b0;
      tdata_q      <= '0;
      skid_q       <= '0;
      tvalid_q     <= 1'b0;
      skid_v_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= w_rd_en;
      if (!w_busy && w_wr && (bus_if.avs_address == 2'd1))
        base_q <= bus_if.avs_writedata[ADDR_WIDTH-1:0];
      if (!w_busy && w_wr && (bus_if.avs_address == 2'd2))
        len_q <= bus_if.avs_writedata[LW-1:0];
      // Clear is applied first so status set by the same edge still wins.
      if (w_clear) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if ((state_q == S_IDLE) && w_start) begin
        if (len_q == '0) begin
          done_q <= 1'b1;
        end else begin
          rem_q     <= len_q;
          ptr_q     <= base_q;
          count_q   <= '0;
          done_q    <= 1'b0;
          aborted_q <= 1'b0;
        end
      end
      if (state_q == S_REQ) begin
        if (w_abort) begin
          aborted_q <= 1'b1;
        end else if (bus_if.dma_ack) begin
          rd_cnt_q <= w_grant;
          hs_cnt_q <= w_grant;
        end
      end
      if ((state_q == S_BURST) && w_abort) abort_pend_q <= 1'b1;
      if (w_rd_en) begin
        ptr_q    <= ptr_q + ADDR_WIDTH'(1);
        rd_cnt_q <= rd_cnt_q - CW'(1);
      end
      if (w_hs) begin
        rem_q    <= rem_q - LW'(1);
        count_q  <= count_q + LW'(1);
        hs_cnt_q <= hs_cnt_q - CW'(1);
      end
      if (w_burst_end) begin
        if (w_last_byte)      done_q    <= 1'b1;
        else if (w_abort_now) aborted_q <= 1'b1;
      end
      if (state_d == S_IDLE) abort_pend_q <= 1'b0;

      if (w_hs || !tvalid_q) begin
        if (skid_v_q) begin
          tdata_q  <= skid_q;
          tvalid_q <= 1'b1;
          skid_v_q <= rd_pend_q;
          if (rd_pend_q) skid_q <= bus_if.mem_rdata;
        end else if (rd_pend_q) begin
          tdata_q  <= bus_if.mem_rdata;
          tvalid_q <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
        end
      end else if (rd_pend_q) begin
        skid_q   <= bus_if.mem_rdata;
        skid_v_q <= 1'b1;
      end
    end
  end

  assign bus_if.avs_readdata   = w_readdata;
  assign bus_if.mem_rd_en      = w_rd_en;
  assign bus_if.mem_addr       = ptr_q;
  assign bus_if.axis4_m_tdata  = tdata_q;
  assign bus_if.axis4_m_tvalid = tvalid_q;
  assign bus_if.axis4_m_tlast  = tvalid_q & w_last_byte;
  assign bus_if.dma_req        = (state_q == S_REQ) & (rem_q >= c_burst_lw);
  assign bus_if.dma_single     = (state_q == S_REQ) & (rem_q <  c_burst_lw);
endmodule
`default_nettype wire
